// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - ISA constants, control types and opcode decoder
package defines;
    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;

    typedef enum logic [3:0] {
        EXE_NOP = 4'd0, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_NOR,
        EXE_XOR, EXE_SLA, EXE_SLL, EXE_SRA, EXE_SRL
    } execmd_t;

    typedef enum logic [1:0] {BR_NONE, BR_BEZ, BR_BNE, BR_JMP} brcmd_t;

    localparam logic [5:0] OP_ADD  = 6'd1,  OP_SUB  = 6'd3,  OP_AND  = 6'd5,
                           OP_OR   = 6'd6,  OP_NOR  = 6'd7,  OP_XOR  = 6'd8,
                           OP_SLA  = 6'd9,  OP_SLL  = 6'd10, OP_SRA  = 6'd11,
                           OP_SRL  = 6'd12, OP_ADDI = 6'd32, OP_SUBI = 6'd33,
                           OP_LD   = 6'd36, OP_ST   = 6'd37, OP_BEZ  = 6'd40,
                           OP_BNE  = 6'd41, OP_JMP  = 6'd42;

    // src2_alt marks ST/BNE, whose second source sits in the dest field
    typedef struct packed {
        execmd_t exe_cmd;
        logic    mem_r_en;
        logic    mem_w_en;
        logic    wb_en;
        logic    is_imm;
        logic    src2_alt;
        brcmd_t  br;
    } dec_t;

    typedef struct packed {
        execmd_t exe_cmd;
        logic    mem_r_en;
        logic    mem_w_en;
        logic    wb_en;
    } id_ex_t;

    localparam id_ex_t ID_EX_NOP = '{exe_cmd: EXE_NOP, mem_r_en: 1'b0,
                                     mem_w_en: 1'b0, wb_en: 1'b0};

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d = '0;
        d.exe_cmd = EXE_NOP;
        d.br = BR_NONE;
        case (op)
            OP_ADD:  begin d.exe_cmd = EXE_ADD; d.wb_en = 1'b1; end
            OP_SUB:  begin d.exe_cmd = EXE_SUB; d.wb_en = 1'b1; end
            OP_AND:  begin d.exe_cmd = EXE_AND; d.wb_en = 1'b1; end
            OP_OR:   begin d.exe_cmd = EXE_OR;  d.wb_en = 1'b1; end
            OP_NOR:  begin d.exe_cmd = EXE_NOR; d.wb_en = 1'b1; end
            OP_XOR:  begin d.exe_cmd = EXE_XOR; d.wb_en = 1'b1; end
            OP_SLA:  begin d.exe_cmd = EXE_SLA; d.wb_en = 1'b1; end
            OP_SLL:  begin d.exe_cmd = EXE_SLL; d.wb_en = 1'b1; end
            OP_SRA:  begin d.exe_cmd = EXE_SRA; d.wb_en = 1'b1; end
            OP_SRL:  begin d.exe_cmd = EXE_SRL; d.wb_en = 1'b1; end
            OP_ADDI: begin d.exe_cmd = EXE_ADD; d.wb_en = 1'b1; d.is_imm = 1'b1; end
            OP_SUBI: begin d.exe_cmd = EXE_SUB; d.wb_en = 1'b1; d.is_imm = 1'b1; end
            OP_LD:   begin d.exe_cmd = EXE_ADD; d.wb_en = 1'b1; d.mem_r_en = 1'b1; d.is_imm = 1'b1; end
            OP_ST:   begin d.exe_cmd = EXE_ADD; d.mem_w_en = 1'b1; d.is_imm = 1'b1; d.src2_alt = 1'b1; end
            OP_BEZ:  begin d.is_imm = 1'b1; d.br = BR_BEZ; end
            OP_BNE:  begin d.is_imm = 1'b1; d.src2_alt = 1'b1; d.br = BR_BNE; end
            OP_JMP:  begin d.is_imm = 1'b1; d.br = BR_JMP; end
            default: ;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/id_stage_pipe_hazard.sv
// rtl/id_stage_pipe_hazard.sv - load-use hazard compare against the ID/EX register
module id_hazard_unit #(
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    i_ex_valid,
    input  logic                    i_ex_mem_r_en,
    input  logic [REG_ADDR_LEN-1:0] i_ex_dest,
    input  logic [REG_ADDR_LEN-1:0] i_src1,
    input  logic [REG_ADDR_LEN-1:0] i_src2,
    input  logic                    i_src2_used,
    output logic                    o_hz
);
    logic w_src_match;

    assign w_src_match = (i_ex_dest == i_src1) || (i_src2_used && (i_ex_dest == i_src2));
    assign o_hz = i_ex_valid && i_ex_mem_r_en && (i_ex_dest != '0) && w_src_match;
endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage with ID/EX register, load-use stall, branch redirect, flush
module id_stage_pipe #(
    parameter int WORD_LEN     = defines::WORD_LEN,
    parameter int REG_ADDR_LEN = defines::REG_FILE_ADDR_LEN,
    parameter int IMM_LEN      = 16,
    parameter int IMM_SIGNED   = 1,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_LEN-1:0]     instr_i,
    input  logic [WORD_LEN-1:0]     pc_i,
    output logic [REG_ADDR_LEN-1:0] rs1_addr_o,
    output logic [REG_ADDR_LEN-1:0] rs2_addr_o,
    input  logic [WORD_LEN-1:0]     rs1_data_i,
    input  logic [WORD_LEN-1:0]     rs2_data_i,
    input  logic                    flush_i,
    output logic                    br_taken_o,
    output logic [WORD_LEN-1:0]     br_target_o,
    output logic                    out_valid,
    input  logic                    out_ready,
    output defines::execmd_t        exe_cmd_o,
    output logic                    mem_r_en_o,
    output logic                    mem_w_en_o,
    output logic                    wb_en_o,
    output logic [WORD_LEN-1:0]     val1_o,
    output logic [WORD_LEN-1:0]     val2_o,
    output logic [WORD_LEN-1:0]     st_val_o,
    output logic [REG_ADDR_LEN-1:0] dest_o,
    output logic [REG_ADDR_LEN-1:0] src1_o,
    output logic [REG_ADDR_LEN-1:0] src2_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        flush_cnt_o
);
    import defines::*;

    dec_t                    w_dec;
    logic [REG_ADDR_LEN-1:0] w_src1, w_src2, w_dest;
    logic                    w_src2_used, w_hz, w_adv, w_accept, w_taken;
    logic [IMM_LEN-1:0]      w_imm_raw;
    logic [WORD_LEN-1:0]     w_imm;

    logic                    r_valid;
    id_ex_t                  r_ctl;
    logic [WORD_LEN-1:0]     r_val1, r_val2, r_st_val;
    logic [REG_ADDR_LEN-1:0] r_dest, r_src1, r_src2;
    logic [CNT_W-1:0]        r_stall_cnt, r_flush_cnt;

    assign w_dec       = decode_op(instr_i[31:26]);
    assign w_src1      = REG_ADDR_LEN'(instr_i[20:16]);
    assign w_dest      = REG_ADDR_LEN'(instr_i[25:21]);
    assign w_src2      = w_dec.src2_alt ? w_dest : REG_ADDR_LEN'(instr_i[15:11]);
    assign w_src2_used = !w_dec.is_imm || w_dec.src2_alt;
    assign rs1_addr_o  = w_src1;
    assign rs2_addr_o  = w_src2;

    assign w_imm_raw   = instr_i[IMM_LEN-1:0];
    assign w_imm       = (IMM_SIGNED != 0)
                       ? {{(WORD_LEN-IMM_LEN){w_imm_raw[IMM_LEN-1]}}, w_imm_raw}
                       : {{(WORD_LEN-IMM_LEN){1'b0}}, w_imm_raw};
    assign br_target_o = pc_i + WORD_LEN'(1) + w_imm;

    id_hazard_unit #(.REG_ADDR_LEN(REG_ADDR_LEN)) u_hazard (
        .i_ex_valid    (r_valid),
        .i_ex_mem_r_en (r_ctl.mem_r_en),
        .i_ex_dest     (r_dest),
        .i_src1        (w_src1),
        .i_src2        (w_src2),
        .i_src2_used   (w_src2_used),
        .o_hz          (w_hz)
    );

    assign w_adv    = out_ready || !r_valid;
    assign in_ready = w_adv && !w_hz && !flush_i;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_taken = 1'b0;
        case (w_dec.br)
            BR_BEZ:  w_taken = (rs1_data_i == '0);
            BR_BNE:  w_taken = (rs1_data_i != rs2_data_i);
            BR_JMP:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end
    assign br_taken_o = w_accept && w_taken;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_ctl       <= ID_EX_NOP;
            r_val1      <= '0;
            r_val2      <= '0;
            r_st_val    <= '0;
            r_dest      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            // flush never accepts (in_ready is low), so it always lands in the bubble branch
            if (flush_i || w_adv) begin
                if (w_accept) begin
                    r_valid  <= 1'b1;
                    r_ctl    <= '{exe_cmd: w_dec.exe_cmd, mem_r_en: w_dec.mem_r_en,
                                  mem_w_en: w_dec.mem_w_en, wb_en: w_dec.wb_en};
                    r_val1   <= rs1_data_i;
                    r_val2   <= w_dec.is_imm ? w_imm : rs2_data_i;
                    r_st_val <= rs2_data_i;
                    r_dest   <= w_dest;
                    r_src1   <= w_src1;
                    r_src2   <= (w_dec.is_imm && !w_dec.src2_alt) ? '0 : w_src2;
                end else begin
                    r_valid        <= 1'b0;
                    r_ctl.mem_r_en <= 1'b0;
                    r_ctl.mem_w_en <= 1'b0;
                    r_ctl.wb_en    <= 1'b0;
                end
            end
            if (in_valid && w_hz && !flush_i && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_i && r_valid && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = r_valid;
    assign exe_cmd_o   = r_ctl.exe_cmd;
    assign mem_r_en_o  = r_ctl.mem_r_en;
    assign mem_w_en_o  = r_ctl.mem_w_en;
    assign wb_en_o     = r_ctl.wb_en;
    assign val1_o      = r_val1;
    assign val2_o      = r_val2;
    assign st_val_o    = r_st_val;
    assign dest_o      = r_dest;
    assign src1_o      = r_src1;
    assign src2_o      = r_src2;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;
    import defines::*;

    logic        clk = 1'b0;
    logic        rstn, in_valid, flush_i, out_ready;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;

    logic        in_ready, br_taken_o, out_valid, mem_r_en_o, mem_w_en_o, wb_en_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, dest_o, src1_o, src2_o;
    logic [31:0] br_target_o, val1_o, val2_o, st_val_o;
    execmd_t     exe_cmd_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic        s_in_ready, s_br_taken, s_out_valid, s_mem_r, s_mem_w, s_wb;
    logic [4:0]  s_rs1_addr, s_rs2_addr, s_dest, s_src1, s_src2;
    logic [31:0] s_br_target, s_val1, s_val2, s_st_val;
    execmd_t     s_exe_cmd;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .br_taken_o(br_taken_o), .br_target_o(br_target_o), .out_valid(out_valid),
        .out_ready(out_ready), .exe_cmd_o(exe_cmd_o), .mem_r_en_o(mem_r_en_o),
        .mem_w_en_o(mem_w_en_o), .wb_en_o(wb_en_o), .val1_o(val1_o), .val2_o(val2_o),
        .st_val_o(st_val_o), .dest_o(dest_o), .src1_o(src1_o), .src2_o(src2_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    id_stage_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready),
        .instr_i(instr_i), .pc_i(pc_i), .rs1_addr_o(s_rs1_addr), .rs2_addr_o(s_rs2_addr),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
        .br_taken_o(s_br_taken), .br_target_o(s_br_target), .out_valid(s_out_valid),
        .out_ready(out_ready), .exe_cmd_o(s_exe_cmd), .mem_r_en_o(s_mem_r),
        .mem_w_en_o(s_mem_w), .wb_en_o(s_wb), .val1_o(s_val1), .val2_o(s_val2),
        .st_val_o(s_st_val), .dest_o(s_dest), .src1_o(s_src1), .src2_o(s_src2),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [5:0] op, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2);
        return {op, d, s1, s2, 11'b0};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] a,
                                           input logic [4:0] s1, input logic [15:0] imm);
        return {op, a, s1, imm};
    endfunction

    initial begin
        rstn = 1'b0; in_valid = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
        instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_exe_cmd", exe_cmd_o, EXE_NOP);
        chk("rst_wb_en", wb_en_o, 0);
        chk("rst_val2", val2_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_flush_cnt", flush_cnt_o, 0);
        chk("rst_in_ready", in_ready, 1);
        tick(); tick();
        rstn = 1'b1;

        // ADDI r1,r2,#-3
        instr_i = i_type(OP_ADDI, 5'd1, 5'd2, 16'hFFFD); rs1_data_i = 32'd7; in_valid = 1'b1;
        #1;
        chk("addi_rs1_addr", rs1_addr_o, 2);
        chk("addi_in_ready", in_ready, 1);
        tick();
        chk("addi_out_valid", out_valid, 1);
        chk("addi_val2", val2_o, 32'hFFFF_FFFD);
        chk("addi_wb_en", wb_en_o, 1);
        chk("addi_exe_cmd", exe_cmd_o, EXE_ADD);
        chk("addi_val1", val1_o, 7);
        chk("addi_dest", dest_o, 1);
        chk("addi_src2_forced", src2_o, 0);

        // LD r3 then dependent ADD r4,r3,r5
        instr_i = i_type(OP_LD, 5'd3, 5'd2, 16'd8);
        tick();
        chk("ld_mem_r_en", mem_r_en_o, 1);
        chk("ld_dest", dest_o, 3);
        instr_i = r_type(OP_ADD, 5'd4, 5'd3, 5'd5); rs1_data_i = 32'd100; rs2_data_i = 32'd50;
        #1;
        chk("hz_in_ready", in_ready, 0);
        tick();
        chk("bubble_out_valid", out_valid, 0);
        chk("bubble_mem_r_en", mem_r_en_o, 0);
        chk("bubble_stall_cnt", stall_cnt_o, 1);
        chk("bubble_in_ready", in_ready, 1);
        tick();
        chk("add_out_valid", out_valid, 1);
        chk("add_exe_cmd", exe_cmd_o, EXE_ADD);
        chk("add_src1", src1_o, 3);
        chk("add_src2", src2_o, 5);
        chk("add_val2", val2_o, 50);
        chk("add_stall_cnt", stall_cnt_o, 1);

        // BNE src2=r2, src1=r1, imm=4 at pc 0x10
        instr_i = i_type(OP_BNE, 5'd2, 5'd1, 16'd4); pc_i = 32'h10;
        rs1_data_i = 32'd5; rs2_data_i = 32'd5;
        #1;
        chk("bne_eq_taken", br_taken_o, 0);
        chk("bne_rs2_addr", rs2_addr_o, 2);
        rs2_data_i = 32'd6;
        #1;
        chk("bne_ne_taken", br_taken_o, 1);
        chk("bne_target", br_target_o, 32'h15);
        tick();
        chk("bne_out_valid", out_valid, 1);
        chk("bne_wb_en", wb_en_o, 0);
        chk("bne_src2", src2_o, 2);

        // BEZ with rs1==0, negative offset
        instr_i = i_type(OP_BEZ, 5'd0, 5'd1, 16'hFFFE); pc_i = 32'h20; rs1_data_i = 32'd0;
        #1;
        chk("bez_taken", br_taken_o, 1);
        chk("bez_target", br_target_o, 32'h1F);
        tick();

        // back-pressure: ADD r6 held while out_ready is low
        instr_i = r_type(OP_ADD, 5'd6, 5'd1, 5'd2); rs1_data_i = 32'd11; rs2_data_i = 32'd22;
        tick();
        out_ready = 1'b0;
        instr_i = r_type(OP_SUB, 5'd7, 5'd1, 5'd2); rs1_data_i = 32'd99; rs2_data_i = 32'd98;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_val1", val1_o, 11);
            chk("bp_val2", val2_o, 22);
            chk("bp_dest", dest_o, 6);
        end

        // flush while stalled downstream
        flush_i = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_wb_en", wb_en_o, 0);
        chk("flush_cnt", flush_cnt_o, 1);
        chk("flush_cnt_sat_dut", s_flush_cnt, 1);
        flush_i = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        tick();
        chk("flush_dropped", out_valid, 0);

        // LD r8 held by back-pressure, dependent ADD stalls 5 cycles
        in_valid = 1'b1; instr_i = i_type(OP_LD, 5'd8, 5'd2, 16'd0);
        tick();
        out_ready = 1'b0;
        instr_i = r_type(OP_ADD, 5'd9, 5'd8, 5'd0);
        #1;
        chk("sat_hz_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("stall_cnt_16", stall_cnt_o, 6);
        chk("stall_cnt_sat", s_stall_cnt, 3);
        chk("ld_held_valid", out_valid, 1);

        // asynchronous reset mid-stall
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_mem_r_en", mem_r_en_o, 0);
        chk("arst_exe_cmd", exe_cmd_o, EXE_NOP);
        chk("arst_dest", dest_o, 0);
        chk("arst_stall_cnt", stall_cnt_o, 0);
        chk("arst_sat_stall", s_stall_cnt, 0);
        chk("arst_sat_valid", s_out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_br_taken", br_taken_o, 0);
        in_valid = 1'b0;
        tick();
        rstn = 1'b1; out_ready = 1'b1;
        tick();
        chk("post_rst_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
